// File: rtl/mmio_seg7_if.sv
// MMIO bus bundle for the seven-segment scanner: level requests from the
// master, a one-cycle done pulse and read data from the slave.
interface mmio_seg7_if;
  logic        mmio_read;
  logic        mmio_write;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_write_data;
  logic        mmio_work;
  logic        mmio_done;
  logic [31:0] mmio_read_data;

  modport master (
    output mmio_read, mmio_write, mmio_addr, mmio_write_data,
    input  mmio_work, mmio_done, mmio_read_data
  );

  modport slave (
    input  mmio_read, mmio_write, mmio_addr, mmio_write_data,
    output mmio_work, mmio_done, mmio_read_data
  );
endinterface

// File: rtl/mmio_seg7.sv
// Eight-digit multiplexed seven-segment driver behind a 32-word MMIO window.
// Optional macro MMIO_SEG7_LZ_BLANK_EN blanks leading zero digits in hex mode.
module mmio_seg7 #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        sys_clk,
  input  logic        rst,
  mmio_seg7_if.slave  mmio,
  output logic [7:0]  seg_n,
  output logic [7:0]  an_n
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [31:0]   data_reg;
  logic [7:0]    dp_reg;
  logic [7:0]    en_reg;
  logic          raw_reg;
  logic          done_reg;
  logic [31:0]   rdata_reg;
  logic [PW-1:0] presc_reg;
  logic [2:0]    digit_reg;
  logic          live_reg;

  logic [4:0]    word_idx;
  logic          accept;
  logic [31:0]   reg_word;
  logic [2:0]    digit_next;
  logic [7:0]    seg_pat [8];
  logic [7:0]    digit_on;
  logic          unused_addr_bits;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign mmio.mmio_work      = (mmio.mmio_addr[31:16] == 16'hFFFF) &&
                               (mmio.mmio_addr[15:7]  == 9'h004);
  assign mmio.mmio_done      = done_reg;
  assign mmio.mmio_read_data = rdata_reg;
  assign unused_addr_bits    = ^mmio.mmio_addr[1:0];

  assign word_idx = mmio.mmio_addr[6:2];
  // The done cycle itself never accepts, which enforces the 2-cycle spacing.
  assign accept   = !done_reg && (mmio.mmio_read || mmio.mmio_write);

  always_comb begin
    reg_word = '0;
    case (word_idx)
      5'd0:    reg_word = data_reg;
      5'd1:    reg_word = {24'd0, dp_reg};
      5'd2:    reg_word = {24'd0, en_reg};
      5'd3:    reg_word = {31'd0, raw_reg};
      default: reg_word = '0;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      done_reg  <= 1'b0;
      rdata_reg <= '0;
      data_reg  <= '0;
      dp_reg    <= '0;
      en_reg    <= 8'hFF;
      raw_reg   <= 1'b0;
    end else begin
      done_reg  <= accept;
      rdata_reg <= '0;
      if (accept) begin
        if (mmio.mmio_write) begin
          case (word_idx)
            5'd0:    data_reg <= mmio.mmio_write_data;
            5'd1:    dp_reg   <= mmio.mmio_write_data[7:0];
            5'd2:    en_reg   <= mmio.mmio_write_data[7:0];
            5'd3:    raw_reg  <= mmio.mmio_write_data[0];
            default: ;
          endcase
        end else begin
          rdata_reg <= reg_word;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      localparam logic IS_UNITS = (gi == 0);
      // Raw mode reuses the four DATA bytes for digits 0-3 and again for 4-7.
      assign seg_pat[gi] = raw_reg ? (data_reg[8*(gi%4) +: 8] | {dp_reg[gi], 7'd0})
                                   : {dp_reg[gi], hex7(data_reg[4*gi +: 4])};
`ifdef MMIO_SEG7_LZ_BLANK_EN
      assign digit_on[gi] = en_reg[gi] &
                            (raw_reg | IS_UNITS | (|data_reg[31:4*gi]));
`else
      assign digit_on[gi] = en_reg[gi] & (IS_UNITS | 1'b1);
`endif
    end
  endgenerate

  assign digit_next = digit_reg + 3'd1;

  // Segments load while anodes are dark in a slot's first cycle; the anode
  // turns on in the second cycle and holds for the rest of the slot.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
      digit_reg <= '0;
      live_reg  <= 1'b0;
      an_n      <= 8'hFF;
      seg_n     <= 8'hFF;
    end else if (presc_reg == PRESC_LAST) begin
      presc_reg <= '0;
      digit_reg <= digit_next;
      live_reg  <= 1'b1;
      an_n      <= 8'hFF;
      seg_n     <= ~seg_pat[digit_next];
    end else begin
      presc_reg <= presc_reg + 1'b1;
      if (presc_reg == '0 && live_reg)
        an_n <= digit_on[digit_reg] ? ~(8'd1 << digit_reg) : 8'hFF;
    end
  end

endmodule

// File: tb/tb_mmio_seg7.sv
// Directed bench for mmio_seg7: register access, handshake timing, scan
// patterns, raw mode, enables, leading-zero option and reset abort.
module tb_mmio_seg7;
  localparam int unsigned SCAN_DIV = 4;
  localparam int SETTLE = 8*SCAN_DIV + 2;

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b1;
  logic [7:0] seg_n;
  logic [7:0] an_n;
  int         tests_run    = 0;
  int         tests_failed = 0;

  mmio_seg7_if bus();

  mmio_seg7 #(.SCAN_DIV(SCAN_DIV)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .mmio    (bus),
    .seg_n   (seg_n),
    .an_n    (an_n)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    int cyc;
    @(negedge sys_clk);
    bus.mmio_write = 1'b1;
    bus.mmio_addr = addr;
    bus.mmio_write_data = data;
    cyc = 0;
    do begin
      @(negedge sys_clk);
      cyc++;
    end while (!bus.mmio_done && cyc < 8);
    check("wr_latency", cyc, 1);
    bus.mmio_write = 1'b0;
    $display("[TB] write %h <= %h", addr, data);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    int cyc;
    @(negedge sys_clk);
    bus.mmio_read = 1'b1;
    bus.mmio_addr = addr;
    cyc = 0;
    do begin
      @(negedge sys_clk);
      cyc++;
    end while (!bus.mmio_done && cyc < 8);
    check("rd_latency", cyc, 1);
    data = bus.mmio_read_data;
    bus.mmio_read = 1'b0;
    @(negedge sys_clk);
    check("rd_data_idle", bus.mmio_read_data, 32'd0);
    $display("[TB] read  %h -> %h", addr, data);
  endtask

  task automatic wait_an(input string tag, input logic [7:0] target);
    bit found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge sys_clk);
      if (an_n == target) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic settle();
    repeat (SETTLE) @(negedge sys_clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic [5:0]  pat;
    logic [7:0]  lit;
    logic [7:0]  prev;
    bit          bad;
    bit          seen;
    bit          ghost;

    bus.mmio_read = 1'b0;
    bus.mmio_write = 1'b0;
    bus.mmio_addr = 32'd0;
    bus.mmio_write_data = 32'd0;

    repeat (3) @(negedge sys_clk);
    check("rst_done", {31'd0, bus.mmio_done}, 32'd0);
    check("rst_rdata", bus.mmio_read_data, 32'd0);
    check("rst_an", {24'd0, an_n}, 32'h0000_00FF);
    check("rst_seg", {24'd0, seg_n}, 32'h0000_00FF);
    rst = 1'b0;

    // Address decode
    bus.mmio_addr = 32'hFFFF_0200; #1 check("work_lo", {31'd0, bus.mmio_work}, 32'd1);
    bus.mmio_addr = 32'hFFFF_027F; #1 check("work_hi", {31'd0, bus.mmio_work}, 32'd1);
    bus.mmio_addr = 32'hFFFF_0280; #1 check("work_above", {31'd0, bus.mmio_work}, 32'd0);
    bus.mmio_addr = 32'hFFFF_01FC; #1 check("work_below", {31'd0, bus.mmio_work}, 32'd0);
    bus.mmio_addr = 32'hFFFE_0200; #1 check("work_upper", {31'd0, bus.mmio_work}, 32'd0);

    // Reset register values
    bus_read(32'hFFFF_0208, rd); check("rst_en", rd, 32'h0000_00FF);
    bus_read(32'hFFFF_0200, rd); check("rst_data", rd, 32'd0);

    // Hex display of 0x12345678
    bus_write(32'hFFFF_0200, 32'h1234_5678);
    settle();
    wait_an("d0_seen", 8'hFE); check("d0_seg", {24'd0, seg_n}, 32'h80);
    wait_an("d4_seen", 8'hEF); check("d4_seg", {24'd0, seg_n}, 32'h99);
    wait_an("d7_seen", 8'h7F); check("d7_seg", {24'd0, seg_n}, 32'hF9);

    // Decimal points, masked upper bits
    bus_write(32'hFFFF_0204, 32'hFFFF_FF0A);
    bus_read(32'hFFFF_0204, rd); check("dp_read", rd, 32'h0000_000A);
    settle();
    wait_an("d1_seen", 8'hFD); check("d1_seg_dp", {24'd0, seg_n}, 32'h78);
    wait_an("d2_seen", 8'hFB); check("d2_seg_nodp", {24'd0, seg_n}, 32'h82);
    wait_an("d3_seen", 8'hF7); check("d3_seg_dp", {24'd0, seg_n}, 32'h12);
    bus_read(32'hFFFF_0201, rd); check("data_read", rd, 32'h1234_5678);
    bus_read(32'hFFFF_020C, rd); check("raw_read", rd, 32'd0);
    bus_write(32'hFFFF_0214, 32'hFFFF_FFFF);
    bus_read(32'hFFFF_0214, rd); check("word5_read", rd, 32'd0);

    // Raw segment mode
    bus_write(32'hFFFF_0204, 32'd0);
    bus_write(32'hFFFF_0200, 32'h3F06_5B4F);
    bus_write(32'hFFFF_020C, 32'd1);
    bus_read(32'hFFFF_020C, rd); check("raw_set", rd, 32'd1);
    settle();
    wait_an("raw_d0_seen", 8'hFE); check("raw_d0_seg", {24'd0, seg_n}, 32'hB0);
    wait_an("raw_d5_seen", 8'hDF); check("raw_d5_seg", {24'd0, seg_n}, 32'hA4);
    wait_an("raw_d7_seen", 8'h7F); check("raw_d7_seg", {24'd0, seg_n}, 32'hC0);
    bus_write(32'hFFFF_020C, 32'd0);

    // Write wins over simultaneous read
    @(negedge sys_clk);
    bus.mmio_write = 1'b1;
    bus.mmio_read = 1'b1;
    bus.mmio_addr = 32'hFFFF_0200;
    bus.mmio_write_data = 32'h0000_00C3;
    @(negedge sys_clk);
    check("both_done", {31'd0, bus.mmio_done}, 32'd1);
    check("both_rdata", bus.mmio_read_data, 32'd0);
    bus.mmio_write = 1'b0;
    bus.mmio_read = 1'b0;
    $display("[TB] write+read %h <= %h", bus.mmio_addr, bus.mmio_write_data);
    bus_read(32'hFFFF_0200, rd); check("both_data", rd, 32'h0000_00C3);

    // Held read: done toggles every other cycle
    @(negedge sys_clk);
    bus.mmio_read = 1'b1;
    bus.mmio_addr = 32'hFFFF_0200;
    for (int i = 0; i < 6; i++) begin
      pat[5-i] = bus.mmio_done;
      if (i < 5) @(negedge sys_clk);
    end
    check("held_rdata", bus.mmio_read_data, 32'h0000_00C3);
    bus.mmio_read = 1'b0;
    check("held_pattern", {26'd0, pat}, 32'b010101);
    $display("[TB] held read done pattern %b", pat);

    // Only digit 0 enabled
    bus_write(32'hFFFF_0208, 32'h0000_0001);
    bad = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge sys_clk);
      if (an_n != 8'hFE && an_n != 8'hFF) bad = 1'b1;
      if (an_n == 8'hFE) seen = 1'b1;
    end
    check("en1_only", {31'd0, bad}, 32'd0);
    check("en1_seen", {31'd0, seen}, 32'd1);
    bus_write(32'hFFFF_0208, 32'h0000_00FF);

    // Leading zeros, anti-ghosting, one-hot anodes
    bus_write(32'hFFFF_0200, 32'h0000_0A50);
    settle();
    lit = 8'd0;
    prev = 8'hFF;
    ghost = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 2*8*SCAN_DIV; i++) begin
      @(negedge sys_clk);
      lit |= ~an_n;
      if (prev != 8'hFF && an_n != 8'hFF && an_n != prev) ghost = 1'b1;
      if ($countones(~an_n) > 1) bad = 1'b1;
      prev = an_n;
    end
    check("no_ghost", {31'd0, ghost}, 32'd0);
    check("an_onehot", {31'd0, bad}, 32'd0);
`ifdef MMIO_SEG7_LZ_BLANK_EN
    check("lz_lit", {24'd0, lit}, 32'h07);
`else
    check("lz_lit", {24'd0, lit}, 32'hFF);
`endif

    // Reset in the done cycle aborts the request
    @(negedge sys_clk);
    bus.mmio_write = 1'b1;
    bus.mmio_addr = 32'hFFFF_0200;
    bus.mmio_write_data = 32'hDEAD_BEEF;
    @(negedge sys_clk);
    rst = 1'b1;
    #1;
    check("abort_done", {31'd0, bus.mmio_done}, 32'd0);
    check("abort_an", {24'd0, an_n}, 32'h0000_00FF);
    bus.mmio_write = 1'b0;
    $display("[TB] write %h <= %h aborted by reset", bus.mmio_addr, bus.mmio_write_data);
    @(negedge sys_clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < int'(SCAN_DIV); i++) begin
      @(negedge sys_clk);
      if (an_n != 8'hFF || bus.mmio_done) bad = 1'b1;
    end
    check("post_rst_dark", {31'd0, bad}, 32'd0);
    bus_read(32'hFFFF_0200, rd); check("post_rst_data", rd, 32'd0);
    bus_read(32'hFFFF_0204, rd); check("post_rst_dp", rd, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
